nibble_stream_rx: RTL and testbench

Receive-side deserializer for the 4-bit nibble result stream that the accelerator wrappers drive off-chip on `data_out`/`data_valid`/`probe_out`. It samples the nibble bus and rebuilds 32-bit result words, LSB nibble first. It frames them into fixed-length frames delimited by the start-of-frame probe, and flags truncated words. It sits in the capture/loopback harness on the far side of the wrapper's output pins, or in the simulation bench in place of file dumps, and feeds a word sink or comparator.

---
 rtl/nibble_stream_rx.sv | 187 ++++++++++++++++++
 tb/tb_nibble_stream_rx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_stream_rx.sv
// -----------------------------------------------------------------------------
// nibble_stream_rx
//
// Receive-side deserializer for the 4-bit nibble result stream driven by the
// accelerator wrappers. Nibbles are packed LSB-first into words of
// NIBBLES_PER_WORD nibbles. Words are counted into frames of WORDS_PER_FRAME
// words, and each frame is opened by the start-of-frame marker. A partial word
// that gets thrown away by a re-sync or an idle timeout raises a sticky
// truncation flag.
//
// Parameters:
//   NIBBLES_PER_WORD : nibbles per word (>= 2); the word is 4*N bits wide
//   WORDS_PER_FRAME  : words per frame, 1..65535
//   IDLE_TIMEOUT     : consecutive non-valid cycles in RECV that abort (>= 2)
//
// Ports:
//   ap_clk        in   sole clock, rising edge
//   ap_rst        in   asynchronous active-high reset
//   data_in       in   4-bit nibble from the transmitter
//   data_in_valid in   nibble qualifier
//   sof_in        in   start-of-frame marker (only meaningful with valid)
//   word_out      out  last assembled word, held between pulses
//   word_valid    out  one-cycle pulse when word_out is new
//   word_count    out  words delivered in the current frame
//   frame_done    out  high while the frame is complete (DONE)
//   err_trunc     out  sticky partial-word-discarded flag
//   busy          out  high while receiving a frame (RECV)
// -----------------------------------------------------------------------------
module nibble_stream_rx #(
  parameter int NIBBLES_PER_WORD = 8,
  parameter int WORDS_PER_FRAME  = 16,
  parameter int IDLE_TIMEOUT     = 64
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  input  logic [3:0]                      data_in,
  input  logic                            data_in_valid,
  input  logic                            sof_in,
  output logic [4*NIBBLES_PER_WORD-1:0]   word_out,
  output logic                            word_valid,
  output logic [15:0]                     word_count,
  output logic                            frame_done,
  output logic                            err_trunc,
  output logic                            busy
);

  localparam int WORD_W = 4 * NIBBLES_PER_WORD;
  localparam int IDX_W  = (NIBBLES_PER_WORD > 1) ? $clog2(NIBBLES_PER_WORD) : 1;
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NIBBLES_PER_WORD - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [15:0]       FRAME_LEN  = 16'(WORDS_PER_FRAME);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDone
  } rxState_e;

  rxState_e            state_q,     state_d;
  logic [WORD_W-1:0]   shift_q,     shift_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic [IDLE_W-1:0]   idleCnt_q,   idleCnt_d;
  logic [WORD_W-1:0]   wordOut_q,   wordOut_d;
  logic                wordValid_q, wordValid_d;
  logic [15:0]         wordCount_q, wordCount_d;
  logic                errTrunc_q,  errTrunc_d;

  logic [WORD_W-1:0]   shiftMerged;
  logic [15:0]         wordCountInc;
  logic [IDLE_W-1:0]   idleCntInc;

  // Shift register with the current nibble dropped into its slot. Used both
  // to keep accumulating and as the completed word on the final nibble, so
  // the last nibble reaches word_out without an extra cycle.
  always_comb begin
    shiftMerged = shift_q;
    for (int i = 0; i < NIBBLES_PER_WORD; i++) begin
      if (idx_q == IDX_W'(i)) begin
        shiftMerged[4*i +: 4] = data_in;
      end
    end
  end

  assign wordCountInc = wordCount_q + 16'd1;
  assign idleCntInc   = idleCnt_q + IDLE_W'(1);

  // Next-state and datapath updates. A valid start-of-frame nibble always
  // wins, in every state, including over a word that would otherwise
  // complete on the same cycle.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    idleCnt_d   = idleCnt_q;
    wordOut_d   = wordOut_q;
    wordValid_d = 1'b0;
    wordCount_d = wordCount_q;
    errTrunc_d  = errTrunc_q;

    if (data_in_valid && sof_in) begin
      // Re-sync mid-word loses the partial word; at a word boundary nothing
      // is lost, so the flag stays untouched.
      if (state_q == StRecv && idx_q != '0) begin
        errTrunc_d = 1'b1;
      end
      shift_d     = WORD_W'(data_in);
      idx_d       = IDX_W'(1);
      wordCount_d = '0;
      idleCnt_d   = '0;
      state_d     = StRecv;
    end else begin
      case (state_q)
        StRecv: begin
          if (data_in_valid) begin
            idleCnt_d = '0;
            if (idx_q == LAST_IDX) begin
              wordOut_d   = shiftMerged;
              wordValid_d = 1'b1;
              idx_d       = '0;
              shift_d     = '0;
              wordCount_d = wordCountInc;
              if (wordCountInc == FRAME_LEN) begin
                state_d = StDone;
              end
            end else begin
              shift_d = shiftMerged;
              idx_d   = idx_q + IDX_W'(1);
            end
          end else begin
            idleCnt_d = idleCntInc;
            // Abort on the edge where the counter reaches the limit; words
            // already delivered and word_count are left as they are.
            if (idleCntInc == IDLE_LIMIT) begin
              if (idx_q != '0) begin
                errTrunc_d = 1'b1;
              end
              idleCnt_d = '0;
              idx_d     = '0;
              shift_d   = '0;
              state_d   = StIdle;
            end
          end
        end
        StIdle, StDone: begin
          // Data without a start marker is dropped here.
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously so a reset in the
  // middle of a word discards it without emitting a pulse.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      idx_q       <= '0;
      idleCnt_q   <= '0;
      wordOut_q   <= '0;
      wordValid_q <= 1'b0;
      wordCount_q <= '0;
      errTrunc_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      idleCnt_q   <= idleCnt_d;
      wordOut_q   <= wordOut_d;
      wordValid_q <= wordValid_d;
      wordCount_q <= wordCount_d;
      errTrunc_q  <= errTrunc_d;
    end
  end

  assign word_out   = wordOut_q;
  assign word_valid = wordValid_q;
  assign word_count = wordCount_q;
  assign frame_done = (state_q == StDone);
  assign busy       = (state_q == StRecv);
  assign err_trunc  = errTrunc_q;

endmodule

// File: tb/tb_nibble_stream_rx.sv
// -----------------------------------------------------------------------------
// tb_nibble_stream_rx
//
// Self-checking bench for nibble_stream_rx (N=8, 2 words per frame, timeout
// 64). A table of vectors covers a full frame; hand-written sequences cover
// gaps, timeout, re-sync, DONE restart and asynchronous reset; a randomized
// run is compared cycle by cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_nibble_stream_rx;

  localparam int N   = 8;
  localparam int WPF = 2;
  localparam int TMO = 64;

  localparam int M_IDLE = 0;
  localparam int M_RECV = 1;
  localparam int M_DONE = 2;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  data_in;
  logic        data_in_valid;
  logic        sof_in;
  logic [31:0] word_out;
  logic        word_valid;
  logic [15:0] word_count;
  logic        frame_done;
  logic        err_trunc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: the word in progress is simply a queue of nibbles.
  int          mMode;
  logic [3:0]  mNib[$];
  int          mGap;
  logic [31:0] mWord;
  logic        mValid;
  logic [15:0] mCount;
  logic        mErr;

  typedef struct {
    logic        v;
    logic        s;
    logic [3:0]  d;
    logic        expValid;
    logic [31:0] expWord;
    logic [15:0] expCount;
    logic        expDone;
    logic        expBusy;
    logic        expErr;
  } vec_t;

  vec_t vecs[17];

  nibble_stream_rx #(
    .NIBBLES_PER_WORD(N),
    .WORDS_PER_FRAME (WPF),
    .IDLE_TIMEOUT    (TMO)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .sof_in       (sof_in),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_count   (word_count),
    .frame_done   (frame_done),
    .err_trunc    (err_trunc),
    .busy         (busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic modelReset();
    mMode  = M_IDLE;
    mNib.delete();
    mGap   = 0;
    mWord  = '0;
    mValid = 1'b0;
    mCount = '0;
    mErr   = 1'b0;
  endtask

  task automatic modelStep(input logic v, input logic s, input logic [3:0] d);
    mValid = 1'b0;
    if (v && s) begin
      if (mMode == M_RECV && mNib.size() != 0) mErr = 1'b1;
      mNib.delete();
      mNib.push_back(d);
      mCount = '0;
      mGap   = 0;
      mMode  = M_RECV;
    end else if (mMode == M_RECV) begin
      if (v) begin
        mGap = 0;
        mNib.push_back(d);
        if (mNib.size() == N) begin
          mWord = '0;
          for (int k = 0; k < N; k++) mWord = mWord | (32'(mNib[k]) << (4 * k));
          mValid = 1'b1;
          mCount = mCount + 16'd1;
          mNib.delete();
          if (int'(mCount) == WPF) mMode = M_DONE;
        end
      end else begin
        mGap++;
        if (mGap >= TMO) begin
          if (mNib.size() != 0) mErr = 1'b1;
          mNib.delete();
          mGap  = 0;
          mMode = M_IDLE;
        end
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic expValid, input logic [31:0] expWord,
                             input logic [15:0] expCount, input logic expDone,
                             input logic expBusy, input logic expErr);
    checkVal({tag, ".word_valid"}, 32'(word_valid), 32'(expValid));
    checkVal({tag, ".word_out"},   word_out,         expWord);
    checkVal({tag, ".word_count"}, 32'(word_count), 32'(expCount));
    checkVal({tag, ".frame_done"}, 32'(frame_done), 32'(expDone));
    checkVal({tag, ".busy"},       32'(busy),       32'(expBusy));
    checkVal({tag, ".err_trunc"},  32'(err_trunc),  32'(expErr));
  endtask

  task automatic checkModel(input string tag);
    checkOutput(tag, mValid, mWord, mCount, mMode == M_DONE, mMode == M_RECV, mErr);
  endtask

  // Drive one cycle of inputs, advance the model on the edge, sample 1ns later.
  task automatic applyStimulus(input logic v, input logic s, input logic [3:0] d);
    data_in_valid = v;
    sof_in        = s;
    data_in       = d;
    @(posedge ap_clk);
    modelStep(v, s, d);
    #1;
  endtask

  task automatic sendWord(input logic [31:0] w, input logic sofFirst, input int gap, input string tag);
    for (int k = 0; k < N; k++) begin
      applyStimulus(1'b1, sofFirst && (k == 0), w[4*k +: 4]);
      checkModel(tag);
      if (k < N - 1) begin
        for (int g = 0; g < gap; g++) begin
          applyStimulus(1'b0, 1'b0, 4'h0);
          checkModel(tag);
        end
      end
    end
  endtask

  task automatic doReset();
    data_in_valid = 1'b0;
    sof_in        = 1'b0;
    data_in       = 4'h0;
    ap_rst        = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    modelReset();
    #1;
    checkOutput("reset", 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    ap_rst        = 1'b1;
    data_in       = 4'h0;
    data_in_valid = 1'b0;
    sof_in        = 1'b0;
    modelReset();
    repeat (2) @(posedge ap_clk);
    #1;
    checkOutput("por", 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    // Table: one contiguous two-word frame plus an ignored nibble in DONE.
    for (int i = 0; i < 16; i++) begin
      vecs[i].v        = 1'b1;
      vecs[i].s        = (i == 0);
      vecs[i].d        = (i < 8) ? 4'(i + 1) : ((i % 2 == 1) ? 4'hF : 4'h0);
      vecs[i].expValid = (i == 7) || (i == 15);
      vecs[i].expWord  = (i < 7) ? 32'h0 : ((i < 15) ? 32'h87654321 : 32'hF0F0F0F0);
      vecs[i].expCount = (i < 7) ? 16'd0 : ((i < 15) ? 16'd1 : 16'd2);
      vecs[i].expDone  = (i == 15);
      vecs[i].expBusy  = (i < 15);
      vecs[i].expErr   = 1'b0;
    end
    vecs[16] = '{1'b1, 1'b0, 4'h5, 1'b0, 32'hF0F0F0F0, 16'd2, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].v, vecs[i].s, vecs[i].d);
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expWord,
                  vecs[i].expCount, vecs[i].expDone, vecs[i].expBusy, vecs[i].expErr);
      checkModel($sformatf("vecm%0d", i));
    end

    // Gapped input: 3 idle cycles between nibbles.
    doReset();
    sendWord(32'h87654321, 1'b1, 3, "gap");
    checkOutput("gap.end", 1'b1, 32'h87654321, 16'd1, 1'b0, 1'b1, 1'b0);

    // Timeout with a partial word, then nibbles without a start marker.
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, k == 0, 4'(k + 1));
      checkModel("tmo.nib");
    end
    for (int k = 0; k < TMO; k++) begin
      applyStimulus(1'b0, 1'b0, 4'h0);
      checkModel("tmo.idle");
    end
    checkOutput("tmo.end", 1'b0, 32'h0, 16'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 4'h9);
      checkModel("tmo.ign");
    end
    checkOutput("tmo.ign.end", 1'b0, 32'h0, 16'd0, 1'b0, 1'b0, 1'b1);

    // Re-sync: one good word, 5 nibbles, then a start marker with nibble A.
    doReset();
    sendWord(32'h11111111, 1'b1, 0, "rs.w0");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 4'h3);
      checkModel("rs.part");
    end
    applyStimulus(1'b1, 1'b1, 4'hA);
    checkOutput("rs.sof", 1'b0, 32'h11111111, 16'd0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 1'b0, 4'h0);
      checkModel("rs.tail");
    end
    checkOutput("rs.end", 1'b1, 32'h0000000A, 16'd1, 1'b0, 1'b1, 1'b1);

    // DONE restart.
    doReset();
    sendWord(32'hDEADBEEF, 1'b1, 0, "dn.w0");
    sendWord(32'h12345678, 1'b0, 0, "dn.w1");
    checkOutput("dn.done", 1'b1, 32'h12345678, 16'd2, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 4'(k));
      checkModel("dn.extra");
    end
    checkOutput("dn.extra.end", 1'b0, 32'h12345678, 16'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'hD);
    checkOutput("dn.restart", 1'b0, 32'h12345678, 16'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k < N; k++) begin
      applyStimulus(1'b1, 1'b0, 4'hC);
      checkModel("dn.next");
    end
    checkOutput("dn.next.end", 1'b1, 32'hCCCCCCCD, 16'd1, 1'b0, 1'b1, 1'b0);

    // Build up non-zero state (err, count, held word), then async reset mid-word.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b0, 4'h7);
      checkModel("ar.pre");
    end
    sendWord(32'h0BADC0DE, 1'b1, 0, "ar.w");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 4'h6);
      checkModel("ar.part");
    end
    checkOutput("ar.before", 1'b0, 32'h0BADC0DE, 16'd1, 1'b0, 1'b1, 1'b1);
    data_in_valid = 1'b0;
    sof_in        = 1'b0;
    #2;
    ap_rst = 1'b1;
    #1;
    checkOutput("ar.async", 1'b0, 32'h0, 16'd0, 1'b0, 1'b0, 1'b0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    modelReset();
    sendWord(32'h5A5AA5A5, 1'b1, 0, "ar.after");
    checkOutput("ar.after.end", 1'b1, 32'h5A5AA5A5, 16'd1, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the reference model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        for (int j = 0; j < TMO + 6; j++) begin
          applyStimulus(1'b0, 1'b0, 4'h0);
          checkModel("rand.gap");
        end
      end else begin
        logic v, s;
        logic [3:0] d;
        v = ($urandom_range(0, 9) < 7);
        s = v && ($urandom_range(0, 49) == 0);
        d = 4'($urandom);
        applyStimulus(v, s, d);
        checkModel("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
